// File: rtl/pixel_layer_arbiter_if.sv
// Pixel layer arbiter bus: pixel stream in, layer-enable configuration,
// and arbitrated palette code / collision statistics out.
// master = pixel source / configuration host, slave = arbiter.
interface pixel_layer_arbiter_if;
    logic        Frame_start;
    logic        Pix_valid;
    logic        Blank_in;
    logic [15:0] Layer_code;
    logic        Cfg_wr;
    logic [3:0]  Cfg_enable;
    logic        Cfg_busy;
    logic [3:0]  Pal_code;
    logic        Pix_valid_out;
    logic [2:0]  Layer_sel;
    logic [15:0] Coll_count;

    modport master (
        output Frame_start, Pix_valid, Blank_in, Layer_code, Cfg_wr, Cfg_enable,
        input  Cfg_busy, Pal_code, Pix_valid_out, Layer_sel, Coll_count
    );

    modport slave (
        input  Frame_start, Pix_valid, Blank_in, Layer_code, Cfg_wr, Cfg_enable,
        output Cfg_busy, Pal_code, Pix_valid_out, Layer_sel, Coll_count
    );
endinterface

// File: rtl/pixel_layer_arbiter.sv
// pixel_layer_arbiter: two-stage priority arbiter over four 4-bit layer
// codes (layer 0 highest priority). Layer enables are written into a shadow
// mask and become active on the next Frame_start so a frame never changes
// mask mid-way.
// Optional feature macro: COLLISION_DETECT_EN adds a saturating per-frame
// count of pixels where layers 1 and 2 are both opaque.
//
// Stream semantics: Pix_valid qualifies the pixel slot in the same cycle;
// there is no backpressure. Results appear on Pal_code/Layer_sel with
// Pix_valid_out exactly two cycles later; while Pix_valid_out is low the
// code and layer outputs hold their last valid values.
module pixel_layer_arbiter #(
    parameter logic [3:0] TRANSPARENT_CODE = 4'h0,
    parameter logic [3:0] BLANK_CODE       = 4'h1,
    parameter logic [3:0] DEFAULT_CODE     = 4'hB
) (
    input  logic                 Clk,
    input  logic                 Reset_n,
    pixel_layer_arbiter_if.slave bus
);

    // Layer-enable configuration state
    logic [3:0]  mask_q, mask_d;
    logic [3:0]  shadow_q, shadow_d;
    logic        busy_q, busy_d;

    // Stage 1: captured pixel plus the opaque vector under the mask in force
    logic        s1_valid_q, s1_valid_d;
    logic        s1_blank_q, s1_blank_d;
    logic [15:0] s1_code_q, s1_code_d;
    logic [3:0]  s1_opaque_q, s1_opaque_d;

    // Stage 2: arbitration result
    logic        s2_valid_q, s2_valid_d;
    logic [3:0]  pal_q, pal_d;
    logic [2:0]  sel_q, sel_d;

    logic [3:0]  win_code;
    logic [2:0]  win_sel;

    // Shadow/active mask handling; a write coincident with Frame_start goes live at once
    always_comb begin
        mask_d   = mask_q;
        shadow_d = shadow_q;
        busy_d   = busy_q;
        if (bus.Cfg_wr && bus.Frame_start) begin
            mask_d   = bus.Cfg_enable;
            shadow_d = bus.Cfg_enable;
            busy_d   = 1'b0;
        end else if (bus.Cfg_wr) begin
            shadow_d = bus.Cfg_enable;
            busy_d   = 1'b1;
        end else if (bus.Frame_start && busy_q) begin
            mask_d   = shadow_q;
            busy_d   = 1'b0;
        end
    end

    // Stage 1 capture; opacity is resolved here so in-flight pixels keep their mask
    always_comb begin
        s1_valid_d  = bus.Pix_valid;
        s1_blank_d  = bus.Blank_in;
        s1_code_d   = bus.Layer_code;
        s1_opaque_d = 4'h0;
        for (int i = 0; i < 4; i++) begin
            s1_opaque_d[i] = mask_q[i] && (bus.Layer_code[i*4 +: 4] != TRANSPARENT_CODE);
        end
    end

    // Priority pick: lowest-numbered opaque layer wins, blanking overrides everything
    always_comb begin
        win_code = DEFAULT_CODE;
        win_sel  = 3'd4;
        for (int i = 3; i >= 0; i--) begin
            if (s1_opaque_q[i]) begin
                win_code = s1_code_q[i*4 +: 4];
                win_sel  = 3'(i);
            end
        end
        if (s1_blank_q) begin
            win_code = BLANK_CODE;
            win_sel  = 3'd5;
        end
    end

    // Stage 2 update; code and layer hold when the slot is empty
    always_comb begin
        s2_valid_d = s1_valid_q;
        pal_d      = pal_q;
        sel_d      = sel_q;
        if (s1_valid_q) begin
            pal_d = win_code;
            sel_d = win_sel;
        end
    end

    // All configuration and pipeline registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            mask_q      <= 4'hF;
            shadow_q    <= 4'hF;
            busy_q      <= 1'b0;
            s1_valid_q  <= 1'b0;
            s1_blank_q  <= 1'b0;
            s1_code_q   <= 16'h0000;
            s1_opaque_q <= 4'h0;
            s2_valid_q  <= 1'b0;
            pal_q       <= BLANK_CODE;
            sel_q       <= 3'd5;
        end else begin
            mask_q      <= mask_d;
            shadow_q    <= shadow_d;
            busy_q      <= busy_d;
            s1_valid_q  <= s1_valid_d;
            s1_blank_q  <= s1_blank_d;
            s1_code_q   <= s1_code_d;
            s1_opaque_q <= s1_opaque_d;
            s2_valid_q  <= s2_valid_d;
            pal_q       <= pal_d;
            sel_q       <= sel_d;
        end
    end

    assign bus.Cfg_busy      = busy_q;
    assign bus.Pal_code      = pal_q;
    assign bus.Pix_valid_out = s2_valid_q;
    assign bus.Layer_sel     = sel_q;

`ifdef COLLISION_DETECT_EN
    logic [15:0] acc_q, acc_d;
    logic [15:0] coll_q, coll_d;

    // Per-frame collision accumulator; Frame_start publishes and clears it
    always_comb begin
        acc_d  = acc_q;
        coll_d = coll_q;
        if (bus.Frame_start) begin
            coll_d = acc_q;
            acc_d  = 16'h0000;
        end else if (s1_valid_q && !s1_blank_q && s1_opaque_q[1] && s1_opaque_q[2]
                     && (acc_q != 16'hFFFF)) begin
            acc_d = acc_q + 16'h0001;
        end
    end

    // Collision registers
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            acc_q  <= 16'h0000;
            coll_q <= 16'h0000;
        end else begin
            acc_q  <= acc_d;
            coll_q <= coll_d;
        end
    end

    assign bus.Coll_count = coll_q;
`else
    assign bus.Coll_count = 16'h0000;
`endif

endmodule

// File: tb/tb_pixel_layer_arbiter.sv
// Bench for pixel_layer_arbiter: directed vectors, a behavioural model
// checked every cycle, and literal expectations for the key scenarios.
module tb_pixel_layer_arbiter;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    pixel_layer_arbiter_if bus ();

    pixel_layer_arbiter dut (
        .Clk     (clk),
        .Reset_n (rst_n),
        .bus     (bus.slave)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    logic        m_mask_busy;
    logic [3:0]  m_mask, m_shadow;
    logic        m_p_v, m_p_b;
    logic [15:0] m_p_code;
    logic [3:0]  m_p_mask;
    logic        m_vout;
    logic [3:0]  m_pal;
    logic [2:0]  m_sel;
    logic [15:0] m_acc, m_coll;

    // Returns {code, layer} by scanning the layers in priority order
    function automatic logic [6:0] arb(input logic [15:0] code, input logic [3:0] mask,
                                       input logic blank);
        if (blank) return {4'h1, 3'd5};
        for (int i = 0; i < 4; i++) begin
            if (mask[i] && (code[i*4 +: 4] != 4'h0)) return {code[i*4 +: 4], 3'(i)};
        end
        return {4'hB, 3'd4};
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_mask <= 4'hF; m_shadow <= 4'hF; m_mask_busy <= 1'b0;
            m_p_v <= 1'b0; m_p_b <= 1'b0; m_p_code <= '0; m_p_mask <= 4'hF;
            m_vout <= 1'b0; m_pal <= 4'h1; m_sel <= 3'd5;
            m_acc <= '0; m_coll <= '0;
        end else begin
            m_p_v    <= bus.Pix_valid;
            m_p_b    <= bus.Blank_in;
            m_p_code <= bus.Layer_code;
            m_p_mask <= m_mask;
            m_vout   <= m_p_v;
            if (m_p_v) {m_pal, m_sel} <= arb(m_p_code, m_p_mask, m_p_b);
            if (bus.Cfg_wr && bus.Frame_start) begin
                m_mask <= bus.Cfg_enable; m_shadow <= bus.Cfg_enable; m_mask_busy <= 1'b0;
            end else if (bus.Cfg_wr) begin
                m_shadow <= bus.Cfg_enable; m_mask_busy <= 1'b1;
            end else if (bus.Frame_start && m_mask_busy) begin
                m_mask <= m_shadow; m_mask_busy <= 1'b0;
            end
`ifdef COLLISION_DETECT_EN
            if (bus.Frame_start) begin
                m_coll <= m_acc;
                m_acc  <= '0;
            end else if (m_p_v && !m_p_b && m_p_mask[1] && m_p_mask[2]
                         && m_p_code[7:4] != 4'h0 && m_p_code[11:8] != 4'h0
                         && m_acc != 16'hFFFF) begin
                m_acc <= m_acc + 16'd1;
            end
`endif
        end
    end

    // ---------------- scoreboard ----------------
    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT against the model on every falling edge out of reset
    always @(negedge clk) begin
        if (rst_n) begin
            chk("m_valid_out", 16'(bus.Pix_valid_out), 16'(m_vout));
            chk("m_pal_code",  16'(bus.Pal_code),      16'(m_pal));
            chk("m_layer_sel", 16'(bus.Layer_sel),     16'(m_sel));
            chk("m_cfg_busy",  16'(bus.Cfg_busy),      16'(m_mask_busy));
            chk("m_coll",      bus.Coll_count,         m_coll);
        end
    end

    // ---------------- driver ----------------
    task automatic step(input logic v, input logic b, input logic [15:0] code,
                        input logic fs = 1'b0, input logic wr = 1'b0,
                        input logic [3:0] en = 4'h0);
        bus.Pix_valid   = v;
        bus.Blank_in    = b;
        bus.Layer_code  = code;
        bus.Frame_start = fs;
        bus.Cfg_wr      = wr;
        bus.Cfg_enable  = en;
        @(negedge clk);
    endtask

    task automatic chk_out(input string name, input logic v, input logic [3:0] pal,
                           input logic [2:0] sel);
        #1;
        chk({name, "_valid"}, 16'(bus.Pix_valid_out), 16'(v));
        chk({name, "_pal"},   16'(bus.Pal_code),      16'(pal));
        chk({name, "_sel"},   16'(bus.Layer_sel),     16'(sel));
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst_n  = 1'b0;
        bus.Pix_valid = 0; bus.Blank_in = 0; bus.Layer_code = '0;
        bus.Frame_start = 0; bus.Cfg_wr = 0; bus.Cfg_enable = '0;
        @(negedge clk);
        @(negedge clk);
        chk_out("reset", 1'b0, 4'h1, 3'd5);
        chk("reset_busy", 16'(bus.Cfg_busy), 16'h0);
        chk("reset_coll", bus.Coll_count, 16'h0);
        rst_n = 1'b1;

        // All layers transparent -> default code
        step(1, 0, 16'h0000);
        step(1, 0, 16'h0000);
        chk_out("default", 1'b1, 4'hB, 3'd4);

        // Empty slots: valid drops, code and layer hold
        step(0, 0, 16'h7350);
        step(0, 0, 16'h7350);
        chk_out("hold", 1'b0, 4'hB, 3'd4);

        // Layer 0 transparent, layer 1 wins
        step(1, 0, 16'h7350);
        step(1, 0, 16'h7350);
        chk_out("l1_win", 1'b1, 4'h5, 3'd1);

        // Shadow write, applied at Frame_start five cycles later
        step(1, 0, 16'h7350, 0, 1, 4'hD);
        #1 chk("busy_set", 16'(bus.Cfg_busy), 16'h1);
        for (int i = 0; i < 4; i++) step(1, 0, 16'h7350);
        #1 chk("busy_held", 16'(bus.Cfg_busy), 16'h1);
        chk_out("pre_frame", 1'b1, 4'h5, 3'd1);
        step(1, 0, 16'h7350, 1);
        #1 chk("busy_clr", 16'(bus.Cfg_busy), 16'h0);
        step(1, 0, 16'h7350);
        chk_out("in_flight", 1'b1, 4'h5, 3'd1);
        step(1, 0, 16'h7350);
        chk_out("new_mask", 1'b1, 4'h3, 3'd2);

        // Blanking overrides opaque layers
        step(1, 1, 16'h2222);
        step(1, 1, 16'h2222);
        chk_out("blank", 1'b1, 4'h1, 3'd5);

        // Write coincident with Frame_start takes effect without busy
        step(1, 0, 16'hA246, 1, 1, 4'h8);
        #1 chk("coinc_busy", 16'(bus.Cfg_busy), 16'h0);
        step(1, 0, 16'hA246);
        step(1, 0, 16'hA246);
        chk_out("only_l3", 1'b1, 4'hA, 3'd3);

`ifdef COLLISION_DETECT_EN
        // 300 colliding pixels in one frame
        step(0, 0, 16'h0000, 1, 1, 4'hF);
        for (int i = 0; i < 300; i++) step(1, 0, 16'h0550);
        step(0, 0, 16'h0000);
        step(0, 0, 16'h0000);
        step(0, 0, 16'h0000, 1);
        #1 chk("coll_300", bus.Coll_count, 16'd300);
        // Saturation
        for (int i = 0; i < 70000; i++) step(1, 0, 16'h0550);
        step(0, 0, 16'h0000);
        step(0, 0, 16'h0000);
        step(0, 0, 16'h0000, 1);
        #1 chk("coll_sat", bus.Coll_count, 16'hFFFF);
`else
        for (int i = 0; i < 20; i++) step(1, 0, 16'h0550);
        step(0, 0, 16'h0000, 1);
        #1 chk("coll_off", bus.Coll_count, 16'h0000);
`endif

        // Asynchronous reset mid-stream with a pending shadow write
        step(1, 0, 16'h0550, 0, 1, 4'h2);
        step(1, 0, 16'h0550);
        #2 rst_n = 1'b0;
        chk_out("async_rst", 1'b0, 4'h1, 3'd5);
        chk("async_busy", 16'(bus.Cfg_busy), 16'h0);
        chk("async_coll", bus.Coll_count, 16'h0);
        @(negedge clk);
        rst_n = 1'b1;
        step(0, 0, 16'h7350);
        step(0, 0, 16'h7350);
        chk_out("post_rst_idle", 1'b0, 4'h1, 3'd5);
        step(1, 0, 16'h7350);
        step(0, 0, 16'h0000);
        chk_out("post_rst_pix", 1'b1, 4'h5, 3'd1);
        step(0, 0, 16'h0000);
        chk_out("post_rst_drop", 1'b0, 4'h5, 3'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
